// File: rtl/std_sram_singleport_ctrl.sv
// -----------------------------------------------------------------------------
// std_sram_singleport_ctrl
//
// Request/response front end for one single-port SRAM with a 1-cycle read
// latency. Accepted requests are turned into SRAM strobes in the same cycle.
// Read data comes back through a small response FIFO, so a stalled consumer
// never loses data.
//
// Handshakes: a transfer happens on a channel in every cycle where valid and
// ready are both high at the rising clock edge. req_ready never looks at
// req_valid. resp_valid/resp_rdata hold steady until they are consumed.
//
// Read credit: each accepted read takes one credit until its response is
// popped. The read is in flight for one cycle and then sits in the FIFO.
// req_ready is low while all RESP_DEPTH credits are in use, and this stalls
// writes as well as reads.
//
// Optional init sweep (macro STD_SRAM_SINGLEPORT_CTRL_INIT_EN): after reset
// the controller writes INIT_VALUE to every address, one per cycle, and only
// then raises init_done and starts taking requests.
//
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   req_valid/req_ready    request handshake
//   req_we/addr/wdata      request payload (1 = write)
//   resp_valid/resp_ready  response handshake
//   resp_rdata             read data, FIFO head
//   sram_en/we/addr/din    SRAM port strobes
//   sram_dout              SRAM read data, valid the cycle after a read strobe
//   init_done              controller is accepting requests
// -----------------------------------------------------------------------------
module std_sram_singleport_ctrl #(
  parameter int unsigned           ADDR_WIDTH = 8,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           RESP_DEPTH = 2,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  sram_en,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout,
  output logic                  init_done
);

  localparam int unsigned     CW       = $clog2(RESP_DEPTH + 1);
  localparam int unsigned     PW       = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam logic [CW:0]     CREDITS  = (CW+1)'(RESP_DEPTH);
  localparam logic [PW-1:0]   PTR_LAST = PW'(RESP_DEPTH - 1);

  logic                  run;
  logic                  fire;
  logic                  push;
  logic                  pop;
  logic                  inflight_q, inflight_d;
  logic [CW-1:0]         count_q, count_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] mem_q [RESP_DEPTH];

`ifdef STD_SRAM_SINGLEPORT_CTRL_INIT_EN
  // Controller FSM; init_done is the visible copy of the state.
  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] sweep_q, sweep_d;
  logic                  sweep_wr;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_INIT;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    if (state_q == ST_INIT) begin
      sweep_d = sweep_q + 1'b1;
      if (sweep_q == '1) begin
        state_d = ST_RUN;
      end
    end
  end

  // No sweep strobe while reset is still asserted, so the SRAM stays quiet
  // during a long reset and the sweep always starts cleanly at address 0.
  assign sweep_wr  = (state_q == ST_INIT) & resetn;
  assign run       = (state_q == ST_RUN);
  assign sram_en   = fire | sweep_wr;
  assign sram_we   = (fire & req_we) | sweep_wr;
  assign sram_addr = sweep_wr ? sweep_q : req_addr;
`else
  logic run_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  assign run       = run_q;
  assign sram_en   = fire;
  assign sram_we   = fire & req_we;
  assign sram_addr = req_addr;
`endif

  assign init_done = run;

  // Credit = reads fired but not yet popped (in flight plus FIFO entries).
  assign req_ready  = run & (({1'b0, count_q} + (CW+1)'(inflight_q)) < CREDITS);
  assign fire       = req_valid & req_ready;

  // Outside a request write the data bus carries the init word. That word is
  // what the init sweep writes, and it is ignored on every other cycle.
  assign sram_din   = fire ? req_wdata : INIT_VALUE;

  // sram_dout is valid exactly one cycle after a read strobe.
  assign push       = inflight_q;
  assign resp_valid = (count_q != '0);
  assign pop        = resp_valid & resp_ready;
  assign resp_rdata = mem_q[rd_ptr_q];

  always_comb begin
    inflight_d = fire & ~req_we;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      inflight_q <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Storage has no reset; the entries are only read while count_q is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= sram_dout;
    end
  end

`ifndef SYNTHESIS
  // The credit rule guarantees a free entry for every returning read.
  always_ff @(posedge clk) begin
    if (resetn && push) begin
      assert (count_q < CW'(RESP_DEPTH));
    end
  end
`endif

endmodule

// File: doc/std_sram_singleport_ctrl.md
Name: std_sram_singleport_ctrl

Overview:
Request/response controller that drives one single-port SRAM (1-cycle read latency, dout valid the cycle after a read strobe). It accepts read/write commands on a valid/ready request channel and issues them as SRAM port strobes. Read data is returned on a valid/ready response channel through an internal response FIFO, so response backpressure never loses data. It sits between a cache/buffer client and the std SRAM macro wrapper.

Parameters:
ADDR_WIDTH, 8, SRAM address width; depth = 2^ADDR_WIDTH
DATA_WIDTH, 32, SRAM word width
RESP_DEPTH, 2, response FIFO entries (>=1); also the limit on outstanding reads
INIT_VALUE, 0, word written to every address during the init sweep (optional feature only)

Ports:
clk  in  1  clock; all state updates on rising edge
resetn  in  1  synchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  controller accepts request this cycle
req_we  in  1  1 = write, 0 = read
req_addr  in  ADDR_WIDTH  request address
req_wdata  in  DATA_WIDTH  write data
resp_valid  out  1  read data available
resp_ready  in  1  consumer takes resp_rdata this cycle
resp_rdata  out  DATA_WIDTH  read data, FIFO head
sram_en  out  1  SRAM enable strobe
sram_we  out  1  SRAM write enable
sram_addr  out  ADDR_WIDTH  SRAM address
sram_din  out  DATA_WIDTH  SRAM write data
sram_dout  in  DATA_WIDTH  SRAM read data, valid the cycle after a read strobe
init_done  out  1  controller is operational

Behaviour:
- Interface: one clock (clk), synchronous active-low reset (resetn), sampled on the rising edge of clk.
- Reset (resetn=0): FIFO emptied (ptrs/count 0), inflight=0, resp_valid=0, req_ready=0, sram_en=0, sram_we=0, init_done=0. Any in-flight read is dropped. resp_rdata is don't-care while resp_valid=0.
- States: INIT (optional feature only), RUN. Without the feature, reset exits to RUN and init_done=1 from the first cycle after resetn rises.
- RUN: req_ready = (inflight + fifo_count < RESP_DEPTH). This is independent of req_valid and req_we, so writes also stall when read credit is exhausted.
- Accept = req_valid & req_ready (fire). In the same cycle: sram_en=1, sram_we=req_we, sram_addr=req_addr, sram_din=req_wdata (combinational pass-through). When there is no fire, sram_en=0 and sram_we=0.
- Read fired in cycle N: inflight=1 during N+1. sram_dout is pushed into the FIFO at the end of N+1. resp_valid=1 from N+2. Latency from read fire to resp_valid is 2 cycles.
- Back-to-back reads: one fire per cycle while credit remains. inflight tracks exactly the previous cycle's read fire.
- Writes produce no response and occupy no credit after their fire cycle. A write followed by a read of the same address in the next cycle returns the new data, per SRAM write-then-read ordering.
- FIFO: pop on resp_valid & resp_ready. Simultaneous push and pop keeps the count unchanged. Pointers wrap modulo RESP_DEPTH. Overflow is impossible by the credit rule; a push when full is an assertion failure.
- resp_rdata and resp_valid hold stable while resp_valid & ~resp_ready.

Optional Feature:
Macro: STD_SRAM_SINGLEPORT_CTRL_INIT_EN
- Defined: after reset, the controller enters INIT. It writes INIT_VALUE to addresses 0..2^ADDR_WIDTH-1, one per cycle (sram_en=1, sram_we=1, sram_addr=sweep counter), with req_ready=0 and init_done=0. After the last address it moves to RUN and sets init_done=1 on the next cycle. The sweep takes exactly 2^ADDR_WIDTH cycles. Reset during INIT restarts the sweep from address 0.
- Undefined: no INIT state, no sweep counter. init_done behaves as described under Behaviour.

Test Plan:
- Reset, then write addr 0x05 data 0xDEADBEEF, then read addr 0x05 -> sram_en/sram_we strobe on the fire cycles; resp_valid 2 cycles after the read fire with resp_rdata=0xDEADBEEF.
- Three back-to-back reads (0x01, 0x02, 0x03) with resp_ready=0 and RESP_DEPTH=2 -> two fire, req_ready drops; after one pop, the third fires; responses arrive in order.
- Write to 0x10 immediately followed by a read of 0x10 -> the read returns the new data.
- resp_valid held with resp_ready=0 for 5 cycles -> resp_rdata stable; the pop and a new push in the same cycle keep fifo_count at 1.
- resetn pulsed low while a read is inflight and the FIFO holds 1 entry -> resp_valid=0 after reset and no stale response ever appears.
- With STD_SRAM_SINGLEPORT_CTRL_INIT_EN, ADDR_WIDTH=4, INIT_VALUE=0xA5 -> 16 write strobes to addresses 0..15, init_done rises, and a read of 0x7 returns 0xA5.
